pipeline_hazard_ctrl: RTL and testbench

- Scoreboard-based stall/flush controller for the 5-stage pipeline (IF, ID, EXE, MEM, WB).
- Tracks in-flight register writes from issue until regfile write completes.
- Stalls PC and IF/ID and injects an ID/EXE bubble on RAW hazards; flushes wrong-path instructions on taken branch/jump from EXE.
- Keeps stall/flush performance counters and a sticky consistency error flag.

---
 rtl/pipeline_hazard_ctrl.sv | 106 ++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Scoreboard stall/flush controller for a 5-stage in-order pipeline.
// Tracks busy destination registers from issue until the regfile write lands.
module pipeline_hazard_ctrl #(
    parameter int WB_LAT = 3,
    parameter int CNT_W  = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             id_valid_i,
    input  logic [4:0]       id_rs1_i,
    input  logic [4:0]       id_rs2_i,
    input  logic             id_re1_i,
    input  logic             id_re2_i,
    input  logic             id_we_i,
    input  logic [4:0]       id_rd_i,
    input  logic             branch_taken_i,
    output logic             pc_stall_o,
    output logic             if_id_stall_o,
    output logic             if_id_flush_o,
    output logic             id_exe_flush_o,
    output logic             issue_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic             sb_err_o
);

    localparam logic [1:0] LAT = 2'(WB_LAT);
    localparam logic [2:0] RUN_LIMIT = 3'(WB_LAT);

    logic [1:0]  busy_cnt [1:31];
    logic [31:0] busy_vec;
    logic [2:0]  run_cnt;
    logic        hazard;
    logic        stall;

    function automatic logic [2:0] sat_inc(input logic [2:0] v);
        return (v == 3'd7) ? v : v + 3'd1;
    endfunction

    // Bit 0 stays clear so x0 reads never match a busy entry.
    always_comb begin
        busy_vec = '0;
        for (int i = 1; i < 32; i++) begin
            busy_vec[i] = (busy_cnt[i] != 2'd0);
        end
    end

    always_comb begin
        hazard = id_valid_i &&
                 ((id_re1_i && busy_vec[id_rs1_i]) || (id_re2_i && busy_vec[id_rs2_i]));
        stall  = hazard && !branch_taken_i;
    end

    // Taken branch wins over a hazard: the ID instruction is on the wrong path.
    always_comb begin
        pc_stall_o     = 1'b0;
        if_id_stall_o  = 1'b0;
        if_id_flush_o  = 1'b0;
        id_exe_flush_o = 1'b0;
        issue_o        = 1'b0;
        if (branch_taken_i) begin
            if_id_flush_o  = 1'b1;
            id_exe_flush_o = 1'b1;
        end else if (hazard) begin
            pc_stall_o     = 1'b1;
            if_id_stall_o  = 1'b1;
            id_exe_flush_o = 1'b1;
        end else begin
            issue_o = id_valid_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 1; i < 32; i++) begin
                busy_cnt[i] <= 2'd0;
            end
        end else begin
            for (int i = 1; i < 32; i++) begin
                if (issue_o && id_we_i && (id_rd_i == 5'(i))) begin
                    busy_cnt[i] <= LAT;
                end else if (busy_cnt[i] != 2'd0) begin
                    busy_cnt[i] <= busy_cnt[i] - 2'd1;
                end
            end
        end
    end

    // A stall longer than the busy window means the scoreboard lost track.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
            run_cnt     <= 3'd0;
            sb_err_o    <= 1'b0;
        end else begin
            stall_cnt_o <= stall_cnt_o + {{(CNT_W-1){1'b0}}, stall};
            flush_cnt_o <= flush_cnt_o + {{(CNT_W-1){1'b0}}, branch_taken_i};
            run_cnt     <= stall ? sat_inc(run_cnt) : 3'd0;
            if (stall && (run_cnt >= RUN_LIMIT)) begin
                sb_err_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: RAW stalls, x0/read-enable cases,
// branch flush priority, WAW re-issue, consistency error flag and async reset.
module tb_pipeline_hazard_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        id_valid_i;
    logic [4:0]  id_rs1_i;
    logic [4:0]  id_rs2_i;
    logic        id_re1_i;
    logic        id_re2_i;
    logic        id_we_i;
    logic [4:0]  id_rd_i;
    logic        branch_taken_i;
    logic        pc_stall_o;
    logic        if_id_stall_o;
    logic        if_id_flush_o;
    logic        id_exe_flush_o;
    logic        issue_o;
    logic [31:0] stall_cnt_o;
    logic [31:0] flush_cnt_o;
    logic        sb_err_o;

    logic [4:0]  outs;
    int          total = 0;
    int          bad   = 0;

    // {pc_stall, if_id_stall, if_id_flush, id_exe_flush, issue}
    localparam logic [4:0] O_IDLE  = 5'b00000;
    localparam logic [4:0] O_ISSUE = 5'b00001;
    localparam logic [4:0] O_STALL = 5'b11010;
    localparam logic [4:0] O_FLUSH = 5'b00110;

    pipeline_hazard_ctrl #(.WB_LAT(3), .CNT_W(32)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .id_valid_i     (id_valid_i),
        .id_rs1_i       (id_rs1_i),
        .id_rs2_i       (id_rs2_i),
        .id_re1_i       (id_re1_i),
        .id_re2_i       (id_re2_i),
        .id_we_i        (id_we_i),
        .id_rd_i        (id_rd_i),
        .branch_taken_i (branch_taken_i),
        .pc_stall_o     (pc_stall_o),
        .if_id_stall_o  (if_id_stall_o),
        .if_id_flush_o  (if_id_flush_o),
        .id_exe_flush_o (id_exe_flush_o),
        .issue_o        (issue_o),
        .stall_cnt_o    (stall_cnt_o),
        .flush_cnt_o    (flush_cnt_o),
        .sb_err_o       (sb_err_o)
    );

    assign outs = {pc_stall_o, if_id_stall_o, if_id_flush_o, id_exe_flush_o, issue_o};

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs1, input logic re1,
                          input logic [4:0] rs2, input logic re2,
                          input logic we, input logic [4:0] rd, input logic br);
        id_valid_i     = v;
        id_rs1_i       = rs1;
        id_re1_i       = re1;
        id_rs2_i       = rs2;
        id_re2_i       = re2;
        id_we_i        = we;
        id_rd_i        = rd;
        branch_taken_i = br;
        #1;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_i = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        chk("reset_outs", 32'(outs), 32'(O_IDLE));
        chk("reset_stall_cnt", stall_cnt_o, 0);
        chk("reset_flush_cnt", flush_cnt_o, 0);
        chk("reset_err", 32'(sb_err_o), 0);
        tick();
        rst_i = 1'b1;
        tick();

        // Back-to-back RAW on x5: three stalls, issue on the fourth cycle
        set_id(1, 0, 0, 0, 0, 1, 5, 0);
        chk("prod_x5_issue", 32'(outs), 32'(O_ISSUE));
        tick();
        set_id(1, 5, 1, 0, 0, 0, 0, 0);
        chk("raw_stall1", 32'(outs), 32'(O_STALL));
        tick();
        chk("raw_stall2", 32'(outs), 32'(O_STALL));
        tick();
        chk("raw_stall3", 32'(outs), 32'(O_STALL));
        tick();
        chk("raw_issue4", 32'(outs), 32'(O_ISSUE));
        chk("raw_stall_cnt", stall_cnt_o, 3);
        tick();

        // Writes to x0 never mark busy; unread operands never stall
        set_id(1, 0, 0, 0, 0, 1, 0, 0);
        chk("prod_x0_issue", 32'(outs), 32'(O_ISSUE));
        tick();
        set_id(1, 0, 1, 0, 1, 0, 0, 0);
        chk("read_x0_issue", 32'(outs), 32'(O_ISSUE));
        tick();
        set_id(1, 0, 0, 0, 0, 1, 9, 0);
        tick();
        set_id(1, 9, 0, 9, 0, 0, 0, 0);
        chk("re_off_issue", 32'(outs), 32'(O_ISSUE));
        tick();

        // rs2 hazard, then a taken branch in the same cycle takes priority
        set_id(1, 0, 0, 9, 1, 0, 0, 0);
        chk("rs2_stall", 32'(outs), 32'(O_STALL));
        set_id(1, 0, 0, 9, 1, 1, 12, 1);
        chk("branch_flush", 32'(outs), 32'(O_FLUSH));
        tick();
        chk("flush_cnt_1", flush_cnt_o, 1);
        chk("stall_cnt_after_br", stall_cnt_o, 3);
        set_id(1, 12, 1, 0, 0, 0, 0, 0);
        chk("flushed_no_set", 32'(outs), 32'(O_ISSUE));
        tick();

        // WAW: re-issue x7 while its entry is 1 -> window restarts at 3
        set_id(1, 0, 0, 0, 0, 1, 7, 0);
        tick();
        set_id(1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        set_id(1, 0, 0, 0, 0, 1, 7, 0);
        chk("waw_reissue", 32'(outs), 32'(O_ISSUE));
        tick();
        set_id(1, 7, 1, 0, 0, 0, 0, 0);
        chk("waw_stall1", 32'(outs), 32'(O_STALL));
        tick();
        chk("waw_stall2", 32'(outs), 32'(O_STALL));
        tick();
        chk("waw_stall3", 32'(outs), 32'(O_STALL));
        tick();
        chk("waw_issue", 32'(outs), 32'(O_ISSUE));
        chk("waw_stall_cnt", stall_cnt_o, 6);
        chk("no_err_yet", 32'(sb_err_o), 0);
        tick();

        // Distance-4 dependence: no stall
        set_id(1, 0, 0, 0, 0, 1, 11, 0);
        tick();
        set_id(1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        tick();
        set_id(1, 11, 1, 0, 0, 0, 0, 0);
        chk("dist4_issue", 32'(outs), 32'(O_ISSUE));
        tick();

        // Pin x5 busy so one reader stalls four cycles in a row
        force dut.busy_vec = 32'h0000_0020;
        set_id(1, 5, 1, 0, 0, 0, 0, 0);
        chk("pinned_stall", 32'(outs), 32'(O_STALL));
        tick();
        tick();
        tick();
        chk("err_after_3", 32'(sb_err_o), 0);
        tick();
        chk("err_after_4", 32'(sb_err_o), 1);
        release dut.busy_vec;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        chk("err_sticky", 32'(sb_err_o), 1);
        chk("stall_cnt_10", stall_cnt_o, 10);

        // Asynchronous reset in the middle of a stall
        set_id(1, 0, 0, 0, 0, 1, 3, 0);
        tick();
        set_id(1, 3, 1, 0, 0, 0, 0, 0);
        chk("pre_reset_stall", 32'(outs), 32'(O_STALL));
        set_id(0, 3, 1, 0, 0, 0, 0, 0);
        rst_i = 1'b0;
        #1;
        chk("midrst_outs", 32'(outs), 32'(O_IDLE));
        chk("midrst_stall_cnt", stall_cnt_o, 0);
        chk("midrst_flush_cnt", flush_cnt_o, 0);
        chk("midrst_err", 32'(sb_err_o), 0);
        rst_i = 1'b1;
        set_id(1, 3, 1, 0, 0, 0, 0, 0);
        chk("post_rst_issue", 32'(outs), 32'(O_ISSUE));
        tick();
        chk("post_rst_stall_cnt", stall_cnt_o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
